palette_fill_master: RTL



---
 rtl/palette_fill_master.sv | 118 +++++++++++
 1 files changed

// File: rtl/palette_fill_master.sv
// rtl/palette_fill_master.sv - palette RAM fill/copy bus master
// Optional brightness scaling of write data: define PALFILL_FADE_EN.
module palette_fill_master #(
   parameter int TIMEOUT_W = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [13:0] base,
   input  logic [13:0] count,
   input  logic        src_mode,
   input  logic [15:0] fill_color,
   output logic        src_rd,
   output logic [13:0] src_addr,
   input  logic [15:0] src_data,
   input  logic [4:0]  fade,
   output logic        pal_cs,
   output logic [13:0] pal_addr,
   output logic [15:0] pal_wdata,
   output logic        pal_rwn,
   output logic        pal_udsn,
   output logic        pal_ldsn,
   input  logic        pal_dtackn,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT_SRC, S_ACCESS, S_RELEASE, S_DONE
   } state_t;

   state_t                state, state_nx;
   logic [13:0]           base_q, count_q, index_q;
   logic                  mode_q, error_q;
   logic [15:0]           fill_q, data_q;
   logic [TIMEOUT_W-1:0]  tcnt_q;
   logic                  dtack_ok, timeout_hit;

   // DTACKn is ignored in the first ACCESS cycle (tcnt_q==0)
   assign dtack_ok    = (state == S_ACCESS) && (tcnt_q != '0) && !pal_dtackn;
   assign timeout_hit = (state == S_ACCESS) && (tcnt_q == '1) && !dtack_ok;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:     if (start) state_nx = (count == 14'd0) ? S_DONE : S_FETCH;
         S_FETCH:    state_nx = mode_q ? S_WAIT_SRC : S_ACCESS;
         S_WAIT_SRC: state_nx = S_ACCESS;
         S_ACCESS: begin
            if (dtack_ok)         state_nx = S_RELEASE;
            else if (timeout_hit) state_nx = S_DONE;
         end
         S_RELEASE:  state_nx = (index_q + 14'd1 == count_q) ? S_DONE : S_FETCH;
         S_DONE:     state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         base_q  <= '0;
         count_q <= '0;
         index_q <= '0;
         mode_q  <= 1'b0;
         fill_q  <= '0;
         data_q  <= '0;
         tcnt_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && start) begin
            base_q  <= base;
            count_q <= count;
            mode_q  <= src_mode;
            fill_q  <= fill_color;
            index_q <= '0;
            error_q <= 1'b0;
         end
         if (state == S_FETCH && !mode_q) data_q <= fill_q;
         if (state == S_WAIT_SRC)         data_q <= src_data;
         tcnt_q <= (state == S_ACCESS) ? tcnt_q + 1'b1 : '0;
         if (timeout_hit)                 error_q <= 1'b1;
         if (state == S_RELEASE)          index_q <= index_q + 14'd1;
      end
   end

   assign pal_cs   = (state == S_ACCESS);
   assign pal_rwn  = !pal_cs;
   assign pal_udsn = !pal_cs;
   assign pal_ldsn = !pal_cs;
   assign pal_addr = base_q + index_q;
   assign src_rd   = (state == S_FETCH) && mode_q;
   assign src_addr = index_q;
   assign busy     = (state != S_IDLE) && (state != S_DONE);
   assign done     = (state == S_DONE);
   assign error    = error_q;

`ifdef PALFILL_FADE_EN
   logic [4:0] fade_sat;
   assign fade_sat = (fade > 5'd16) ? 5'd16 : fade;

   function automatic logic [3:0] scale(input logic [3:0] n, input logic [4:0] f);
      logic [8:0] p;
      p = 9'(n) * 9'(f);
      return p[7:4];
   endfunction

   assign pal_wdata = {scale(data_q[15:12], fade_sat), scale(data_q[11:8], fade_sat),
                       scale(data_q[7:4], fade_sat), data_q[3:0]};
`else
   logic unused_fade;
   assign unused_fade = ^fade;
   assign pal_wdata   = data_q;
`endif

endmodule
